// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag helpers for the multi-cycle ALU.
// Opcodes 10-13 only execute when ALU_MULDIV_EN is defined.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_MUL   = 4'd10,
        ALU_MULHU = 4'd11,
        ALU_DIVU  = 4'd12,
        ALU_REMU  = 4'd13
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The engine sees op[1:0]: bit 1 selects multiply, bit 0 selects the high half / remainder.
    localparam logic [1:0] MD_DIVU  = 2'b00;
    localparam logic [1:0] MD_REMU  = 2'b01;
    localparam logic [1:0] MD_MUL   = 2'b10;
    localparam logic [1:0] MD_MULHU = 2'b11;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op >= 4'd10) && (op <= 4'd13);
    endfunction

    function automatic logic calc_over(input logic is_add, input logic is_sub,
                                       input logic a_msb, input logic b_msb,
                                       input logic y_msb);
        logic ovf;
        ovf = 1'b0;
        if (is_add)
            ovf = (a_msb == b_msb) && (y_msb != a_msb);
        else if (is_sub)
            ovf = (a_msb != b_msb) && (y_msb != a_msb);
        return ovf;
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Operand/result channel of the multi-cycle ALU, plus the synchronous flush.
// Handshake: a beat transfers on a rising clk edge where valid & ready are both high;
// valid never waits on ready, and the payload must stay stable while valid is high and ready low.
interface alu_multicycle_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] y;
    logic            zero;
    logic            neg;
    logic            carry;
    logic            over;
    logic            illegal;

    modport master (
        output flush, in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, zero, neg, carry, over, illegal
    );

    modport slave (
        input  flush, in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, zero, neg, carry, over, illegal
    );
endinterface

// File: rtl/alu_iter_muldiv.sv
// Bit-serial engine: shift-add multiply and restoring divide, one bit per clock.
// result/done are combinational so the caller can register the final step directly.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            abort,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic [XLEN-1:0]  hi;
    logic [XLEN-1:0]  lo;
    logic [XLEN-1:0]  operand_b;
    logic [XLEN-1:0]  hi_nx;
    logic [XLEN-1:0]  lo_nx;
    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    div_shift;
    logic [XLEN:0]    div_diff;

    // hi holds the upper product / partial remainder, lo the multiplier / dividend-quotient.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand_b} : {(XLEN+1){1'b0}});
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, operand_b};
        if (op_q[1]) begin
            hi_nx = mul_sum[XLEN:1];
            lo_nx = {mul_sum[0], lo[XLEN-1:1]};
        end else begin
            hi_nx = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            lo_nx = {lo[XLEN-2:0], ~div_diff[XLEN]};
        end
        result = op_q[0] ? hi_nx : lo_nx;
    end

    assign done = busy && (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            cnt       <= '0;
            op_q      <= MD_MUL;
            hi        <= '0;
            lo        <= '0;
            operand_b <= '0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            cnt       <= CNT_W'(XLEN);
            op_q      <= op;
            hi        <= '0;
            lo        <= a;
            operand_b <= b;
        end else if (busy) begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// XLEN-wide ALU with valid/ready handshakes, registered result and flags.
// Define ALU_MULDIV_EN to build the iterative MUL/MULHU/DIVU/REMU engine; otherwise 10-13 are reserved.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    alu_multicycle_if.slave    bus,
    output state_t             state
);
    localparam int SH_W = $clog2(XLEN);

    logic            accept;
    logic            go_busy;
    logic            iter_busy;
    logic            iter_done;
    logic [XLEN-1:0] iter_result;
    logic [XLEN:0]   sum_add;
    logic [XLEN:0]   sum_sub;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] res_y;
    logic            res_carry;
    logic            res_over;
    logic            res_illegal;

    assign bus.in_ready = !bus.flush &&
                          ((state == IDLE) || ((state == DONE) && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;
    assign shamt        = bus.b[SH_W-1:0];

`ifdef ALU_MULDIV_EN
    logic iter_start;

    // A zero divisor takes the single-cycle path instead of the engine.
    assign go_busy    = is_muldiv(bus.op) && !(!bus.op[1] && (bus.b == '0));
    assign iter_start = accept && go_busy;

    alu_iter_muldiv #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .abort  (bus.flush),
        .start  (iter_start),
        .op     (bus.op[1:0]),
        .a      (bus.a),
        .b      (bus.b),
        .busy   (iter_busy),
        .done   (iter_done),
        .result (iter_result)
    );
`else
    assign go_busy     = 1'b0;
    assign iter_busy   = 1'b0;
    assign iter_done   = 1'b0;
    assign iter_result = '0;
`endif

    always_comb begin
        sum_add     = {1'b0, bus.a} + {1'b0, bus.b};
        sum_sub     = {1'b0, bus.a} + {1'b0, ~bus.b} + {{XLEN{1'b0}}, 1'b1};
        res_y       = '0;
        res_carry   = 1'b0;
        res_illegal = 1'b0;
        case (bus.op)
            ALU_ADD:  begin res_y = sum_add[XLEN-1:0]; res_carry = sum_add[XLEN]; end
            ALU_SUB:  begin res_y = sum_sub[XLEN-1:0]; res_carry = sum_sub[XLEN]; end
            ALU_AND:  res_y = bus.a & bus.b;
            ALU_OR:   res_y = bus.a | bus.b;
            ALU_XOR:  res_y = bus.a ^ bus.b;
            ALU_SLT:  res_y = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            ALU_SLTU: res_y = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            ALU_SLL:  res_y = bus.a << shamt;
            ALU_SRL:  res_y = bus.a >> shamt;
            ALU_SRA:  res_y = $signed(bus.a) >>> shamt;
            ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU: begin
`ifdef ALU_MULDIV_EN
                // Only reached for the divide-by-zero fast path.
                if (bus.op == ALU_DIVU)
                    res_y = '1;
                else if (bus.op == ALU_REMU)
                    res_y = bus.a;
`else
                res_illegal = 1'b1;
`endif
            end
            default:  res_illegal = 1'b1;
        endcase
        res_over = calc_over(bus.op == ALU_ADD, bus.op == ALU_SUB,
                             bus.a[XLEN-1], bus.b[XLEN-1], res_y[XLEN-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.y         <= '0;
            bus.zero      <= 1'b0;
            bus.neg       <= 1'b0;
            bus.carry     <= 1'b0;
            bus.over      <= 1'b0;
            bus.illegal   <= 1'b0;
        end else if (bus.flush) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (go_busy) begin
                            state         <= BUSY;
                            bus.out_valid <= 1'b0;
                        end else begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.y         <= res_y;
                            bus.zero      <= ~|res_y;
                            bus.neg       <= res_y[XLEN-1];
                            bus.carry     <= res_carry;
                            bus.over      <= res_over;
                            bus.illegal   <= res_illegal;
                        end
                    end else if ((state == DONE) && bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (iter_done) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.y         <= iter_result;
                        bus.zero      <= ~|iter_result;
                        bus.neg       <= iter_result[XLEN-1];
                        bus.carry     <= 1'b0;
                        bus.over      <= 1'b0;
                        bus.illegal   <= 1'b0;
                    end else if (!iter_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed scoreboard bench for alu_multicycle; MUL/DIV expectations follow ALU_MULDIV_EN.
// Expected packed response: {illegal, over, carry, neg, zero, y}.
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int XLEN = 32;
    localparam int W    = XLEN + 5;
`ifdef ALU_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic   clk;
    logic   rst;
    state_t dut_state;
    int     cyc;
    int     errors;
    int     checks;
    bit     seen;
    int     first_cyc;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           acc_q[$];

    alu_multicycle_if #(.XLEN(XLEN)) bus ();

    alu_multicycle #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .state (dut_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] outs();
        return {bus.illegal, bus.over, bus.carry, bus.neg, bus.zero, bus.y};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_op(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [XLEN-1:0] ey, input logic ec, input logic eo,
                            input int elat, input bit md);
        int  n;
        logic ill;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        #1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for op %0d", op);
        end else begin
            ill = (op >= 4'd14);
            if (md && !MD_EN) begin
                ey   = '0;
                ec   = 1'b0;
                eo   = 1'b0;
                elat = 1;
                ill  = 1'b1;
            end
            exp_q.push_back({ill, eo, ec, ey[XLEN-1], (ey == '0), ey});
            lat_q.push_back(elat);
            acc_q.push_back(cyc);
        end
        @(posedge clk);
    endtask

    task automatic issue(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] ey, input logic ec, input logic eo,
                         input int elat, input bit md);
        @(negedge clk);
        drive_op(op, a, b, ey, ec, eo, elat, md);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
    endtask

    // Starts an op that is still in flight (or held in DONE) ten cycles later.
    task automatic start_long_op(input logic [3:0] op);
        if (MD_EN) begin
            issue(op, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, XLEN + 1, 1'b1);
        end else begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            drive_op(ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1, 1'b0);
        end
        idle();
        repeat (9) @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    always begin
        @(negedge clk);
        #2;
        if (rst || bus.flush) begin
            seen = 1'b0;
        end else if (bus.out_valid) begin
            if (!seen) begin
                seen      = 1'b1;
                first_cyc = cyc;
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got y=%h with nothing expected", bus.y);
            end else begin
                chk("result", 64'(outs()), 64'(exp_q[0]));
                if (bus.out_ready) begin
                    chk("latency", 64'(first_cyc - acc_q[0]), 64'(lat_q[0]));
                    void'(exp_q.pop_front());
                    void'(lat_q.pop_front());
                    void'(acc_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        cyc           = 0;
        errors        = 0;
        checks        = 0;
        seen          = 1'b0;
        first_cyc     = 0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 4'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        @(negedge clk);
        #1;
        chk("reset_outputs", 64'(outs()), 64'd0);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_state", 64'(dut_state), 64'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // Back-to-back single-cycle ops with out_ready held high.
        issue(ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1, 1'b0);
        issue(ALU_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1, 1'b0);
        issue(ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1, 1'b0);
        issue(ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1, 1'b0);
        issue(ALU_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1, 1'b0);
        issue(ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1, 1'b0);
        issue(ALU_OR,   32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0, 1, 1'b0);
        issue(ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0, 1, 1'b0);
        issue(ALU_SLL,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1'b0, 1'b0, 1, 1'b0);
        issue(ALU_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0, 1, 1'b0);
        issue(ALU_SRA,  32'h7FFF_FFF0, 32'h0000_0004, 32'h07FF_FFFF, 1'b0, 1'b0, 1, 1'b0);
        issue(ALU_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 1'b0);
        issue(ALU_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1, 1'b0);
        issue(ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1, 1'b0);
        issue(4'd15,    32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0, 1, 1'b0);
        issue(4'd14,    32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1, 1'b0);
        issue(ALU_DIVU, 32'h0000_0009, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 1'b1);
        issue(ALU_REMU, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 1'b0, 1'b0, 1, 1'b1);
        idle();
        drain();

        // Iterative ops, one at a time.
        issue(ALU_MUL, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b0, 1'b0, XLEN + 1, 1'b1);
        idle();
`ifdef ALU_MULDIV_EN
        chk("busy_state", 64'(dut_state), 64'(BUSY));
        for (int i = 0; i < 30; i++) begin
            #1;
            chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
            @(negedge clk);
        end
`endif
        drain();
        issue(ALU_MULHU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b0, XLEN + 1, 1'b1);
        idle();
        drain();
        issue(ALU_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, XLEN + 1, 1'b1);
        idle();
        drain();
        issue(ALU_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, XLEN + 1, 1'b1);
        idle();
        drain();

        // Backpressure: result held for five cycles, then release and a new accept together.
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_op(ALU_SRA, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);
        drive_op(ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, 1'b0);
        idle();
        drain();

        // Flush of an in-flight (or held) op.
        start_long_op(ALU_MUL);
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        clear_sb();
        bus.out_ready = 1'b1;
        #1;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_state", 64'(dut_state), 64'(IDLE));
        repeat (40) @(negedge clk);

        // Asynchronous reset of an in-flight (or held) op.
        start_long_op(ALU_DIVU);
        @(negedge clk);
        rst = 1'b1;
        #1;
        clear_sb();
        bus.out_ready = 1'b1;
        chk("rst_outputs", 64'(outs()), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_state", 64'(dut_state), 64'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Recovery after abort.
        issue(ALU_XOR, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1'b0, 1'b0, 1, 1'b0);
        issue(4'd10,   32'h0000_0003, 32'h0000_0003, 32'h0000_0009, 1'b0, 1'b0, XLEN + 1, 1'b1);
        idle();
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
